// File: rtl/credit_pkg.sv
// Shared definitions for the credit-based send and receive sides:
// counter width helper and credit error flag encoding.
package credit_pkg;

  function automatic int unsigned credit_count_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  typedef enum logic {
    CREDIT_OK       = 1'b0,
    CREDIT_OVERFLOW = 1'b1
  } credit_err_e;

endpackage

// File: rtl/credit_send_unit_if.sv
// Handshake bundle between the upstream en/rdy queue, the send unit and the
// downstream credit-managed receiver.
interface credit_send_unit_if #(
  parameter int data_width = 32
);
  logic                  deq_en;
  logic                  deq_rdy;
  logic [data_width-1:0] deq_msg;
  logic                  send_en;
  logic [data_width-1:0] send_msg;
  logic                  credit_en;

  modport master (
    output deq_en, send_en, send_msg,
    input  deq_rdy, deq_msg, credit_en
  );

  modport slave (
    input  deq_en, send_en, send_msg,
    output deq_rdy, deq_msg, credit_en
  );
endinterface

// File: rtl/credit_send_unit_counter.sv
// Saturating up/down credit counter with a sticky overflow flag raised when a
// credit arrives while every credit is already home.
import credit_pkg::*;

module credit_counter #(
  parameter int num_credits = 2,
  parameter int count_width = credit_count_width(num_credits)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inc,
  input  logic                   dec,
  output logic [count_width-1:0] count,
  output logic                   overflow
);

  localparam logic [count_width-1:0] FULL = count_width'(num_credits);

  credit_err_e err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= FULL;
      err_q <= CREDIT_OK;
    end else begin
      unique case ({inc, dec})
        2'b10: begin
          if (count == FULL) err_q <= CREDIT_OVERFLOW;
          else               count <= count + count_width'(1);
        end
        2'b01:   count <= count - count_width'(1);
        default: ;
      endcase
    end
  end

  assign overflow = (err_q == CREDIT_OVERFLOW);

endmodule

// File: rtl/credit_send_unit.sv
// Credit-based sender: pops the upstream queue only while a downstream slot is
// available and presents the popped message one cycle later.
import credit_pkg::*;

module credit_send_unit #(
  parameter int data_width  = 32,
  parameter int num_credits = 2,
  parameter int count_width = credit_count_width(num_credits)
) (
  input  logic                   clk,
  input  logic                   reset,
  credit_send_unit_if.master     bus,
  output logic [count_width-1:0] credit_count,
  output logic                   idle,
  output logic                   credit_err
);

  logic                  send_en_q;
  logic [data_width-1:0] send_msg_q;
  logic                  pop;

  // Gated by reset so no pop is signalled while the unit is held in reset.
  assign pop        = reset & bus.deq_rdy & (credit_count != '0);
  assign bus.deq_en = pop;

  credit_counter #(
    .num_credits (num_credits),
    .count_width (count_width)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .inc      (bus.credit_en),
    .dec      (pop),
    .count    (credit_count),
    .overflow (credit_err)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      send_en_q  <= 1'b0;
      send_msg_q <= '0;
    end else begin
      send_en_q <= pop;
      if (pop) send_msg_q <= bus.deq_msg;
    end
  end

  assign bus.send_en  = send_en_q;
  assign bus.send_msg = send_msg_q;
  assign idle         = (credit_count == count_width'(num_credits)) & ~send_en_q;

endmodule

// File: doc/credit_send_unit.md
CREDIT_SEND_UNIT -- requirements
Module: credit_send_unit

Interface
REQ-001 SHALL have parameter data_width, default 32, giving the message width in bits.
REQ-002 SHALL have parameter num_credits, default 2, giving the downstream buffer depth in entries, with a minimum of 1.
REQ-003 SHALL have parameter count_width, default $clog2(num_credits+1), giving the credit counter width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port deq_en, output, 1 bit: pops the upstream en/rdy queue this cycle.
REQ-007 SHALL have port deq_rdy, input, 1 bit: the upstream queue is non-empty.
REQ-008 SHALL have port deq_msg, input, data_width bits: the upstream head message.
REQ-009 SHALL have port send_en, output, 1 bit: send_msg is valid and consumes one downstream slot.
REQ-010 SHALL have port send_msg, output, data_width bits: the outgoing message.
REQ-011 SHALL have port credit_en, input, 1 bit: the downstream receiver freed one slot.
REQ-012 SHALL have port credit_count, output, count_width bits: credits currently available.
REQ-013 SHALL have port idle, output, 1 bit: all credits are home and no send is in flight.
REQ-014 SHALL have port credit_err, output, 1 bit: sticky flag set on a credit return while the counter is full.

Function
REQ-015 SHALL drive deq_en = deq_rdy & (credit_count != 0), combinationally; this is the only pop condition.
REQ-016 SHALL register the output: on a cycle with deq_en=1, the next posedge sets send_en=1 and send_msg=deq_msg, so latency is exactly 1 cycle from pop to send.
REQ-017 SHALL set send_en=0 on a cycle with no pop, and SHALL hold send_msg at its previous value.
REQ-018 SHALL update the credit counter as follows: deq_en only -> count-1; credit_en only -> count+1; both or neither -> unchanged.
REQ-019 SHALL make a credit returned in cycle t usable for a pop in cycle t+1; there is no combinational credit bypass.
REQ-020 SHALL treat count==0 with deq_rdy=1 as a stall: deq_en=0, and the counter is unchanged unless credit_en is asserted.
REQ-021 SHALL, on credit_en=1 with count==num_credits and deq_en=0, leave the counter saturated at num_credits and set credit_err=1 until reset.
REQ-022 SHALL never underflow the counter; REQ-015 guarantees this.
REQ-023 SHALL drive idle = (credit_count == num_credits) & ~send_en, combinationally.
REQ-024 SHALL sustain a throughput of 1 message per cycle when num_credits covers the round trip.

Reset
REQ-025 SHALL, while reset=0, asynchronously force credit_count=num_credits, send_en=0, send_msg=0 and credit_err=0.
REQ-026 SHALL force deq_en=0 while reset=0, including assertion of reset mid-stream; messages in flight are discarded.
REQ-027 SHALL resume popping on the first posedge after reset deasserts if deq_rdy=1.

Structure
REQ-028 SHALL place the shared credit-counter width function and the error-flag encoding in package credit_pkg, shared with the matching receive side.
REQ-029 SHALL implement the saturating up/down counter as sub-module credit_counter (inc, dec, count, overflow); the output register and handshake logic stay in the top module.

Verification
REQ-030 SHALL cover reset defaults: hold reset=0 -> credit_count=2, send_en=0, credit_err=0, deq_en=0 even with deq_rdy=1.
REQ-031 SHALL cover credit exhaustion: num_credits=2, deq_rdy=1 constantly, no credits returned, msgs 0xA, 0xB, 0xC -> send_en on cycles 1 and 2 with 0xA then 0xB, then stall with deq_en=0 and count=0.
REQ-032 SHALL cover credit return: from count=0, pulse credit_en in cycle t -> deq_en=1 in cycle t+1 and send_en=1 with 0xC in cycle t+2.
REQ-033 SHALL cover simultaneous events: count=1, deq_en and credit_en in the same cycle -> count stays 1 and send proceeds.
REQ-034 SHALL cover overflow: count=2, idle=1, pulse credit_en -> count stays 2, credit_err=1 and stays set.
REQ-035 SHALL cover mid-stream reset: assert reset=0 one cycle after a pop -> send_en=0 immediately and count=2 after release.
